prog_loader: RTL
================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to begin a program load.
REQ-004 SHALL have port in_valid, input, 1 bit: the source presents a nibble.
REQ-005 SHALL have port in_nibble, input, 4 bits: load data, sent low nibble first.
REQ-006 SHALL have port in_ready, output, 1 bit: the loader accepts a nibble this cycle.
REQ-007 SHALL have port wr_en, output, 1 bit: one-cycle write strobe to program memory.
REQ-008 SHALL have port wr_addr, output, addr_t: program memory write address.
REQ-009 SHALL have port wr_data, output, data_t: assembled program byte.
REQ-010 SHALL have port cpu_hold, output, 1 bit: keeps the cpu in reset while a load is in progress.
REQ-011 SHALL have port done, output, 1 bit: the load has completed.
REQ-012 SHALL have port error, output, 1 bit: checksum mismatch (see Configuration).

Function
REQ-013 SHALL implement states IDLE, LO, HI, WRITE and DONE, plus CK_LO and CK_HI when the checksum feature is compiled in.
REQ-014 SHALL treat a nibble as transferred only in a cycle where in_valid && in_ready.
REQ-015 SHALL drive in_ready = 1 only in LO, HI, CK_LO and CK_HI.
REQ-016 SHALL, from IDLE or DONE on start, go to LO, set wr_addr = 0, clear done and error, and set cpu_hold = 1.
REQ-017 SHALL ignore start in every state other than IDLE and DONE.
REQ-018 LO: on transfer, latch the low nibble and go to HI. HI: on transfer, latch the high nibble and go to WRITE.
REQ-019 WRITE SHALL last exactly one cycle with wr_en = 1 and wr_data = {hi, lo}, i.e. one cycle after the HI transfer.
REQ-020 After WRITE, SHALL increment wr_addr and go to LO, unless wr_addr = 15, in which case SHALL go to DONE (or to CK_LO when the checksum is enabled).
REQ-021 SHALL keep wr_addr at 15 after the last write; it SHALL NOT wrap to 0 until the next start.
REQ-022 SHALL, in DONE, drive done = 1 and cpu_hold = 0; done SHALL stay at 1 until reset or a new start.
REQ-023 SHALL hold state unchanged while in_valid = 0; no timeout is required.
REQ-024 SHALL keep wr_en = 0 outside WRITE, and wr_data stable outside WRITE.

Reset
REQ-025 SHALL, on reset in any state including mid-load, enter IDLE and drive in_ready = 0, wr_en = 0, wr_addr = 0, wr_data = 0, cpu_hold = 0, done = 0, error = 0.
REQ-026 SHALL give reset priority over start and over any in-flight transfer in the same cycle; a partial load is abandoned and no wr_en is emitted.

Configuration
REQ-027 With LOADER_CHECKSUM_EN defined, SHALL accumulate the 16 written bytes mod 256, then receive one checksum byte via CK_LO/CK_HI (low nibble first).
REQ-028 With LOADER_CHECKSUM_EN defined, SHALL go to DONE and set error = 1 if (sum + checksum) mod 256 != 0, otherwise leave error = 0.
REQ-029 Without LOADER_CHECKSUM_EN, SHALL omit CK_LO/CK_HI and the accumulator, tie error to 0, and keep the same port list.

Structure
REQ-030 SHALL take addr_t (4 bits) and data_t (8 bits) from the shared types header.
REQ-031 SHALL place loader_state_t and the constant PROG_WORDS = 16 in the shared types header.
REQ-032 SHALL place the checksum accumulator in sub-module loader_cksum, instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-033 Bench SHALL: start, then nibbles 0x3,0xB for word 0 with in_valid held high -> wr_en for one cycle with wr_addr = 0, wr_data = 0xB3, one cycle after the second transfer.
REQ-034 Bench SHALL: load a full image of 16 words 0x00..0x0F -> 16 wr_en pulses at addresses 0..15, then done = 1, cpu_hold = 0, wr_addr = 15.
REQ-035 Bench SHALL: drop in_valid for 5 cycles between the LO and HI nibbles -> no wr_en during the gap, and the byte is correct once in_valid resumes.
REQ-036 Bench SHALL: assert reset after 7 words have been written -> all outputs at reset values the next cycle; a new start writes word 0 at address 0.
REQ-037 Bench SHALL: assert start in HI -> ignored, and the load continues unchanged.
REQ-038 Bench SHALL, with LOADER_CHECKSUM_EN: 16 bytes of 0x01 and checksum 0xF0 -> error = 0; checksum 0xF1 -> error = 1, done = 1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader types, state encoding and image size.
// CK_LO/CK_HI exist only when LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;
    typedef logic [3:0] addr_t;
    typedef logic [7:0] data_t;
    localparam int PROG_WORDS = 16;
    localparam addr_t LAST_ADDR = addr_t'(PROG_WORDS - 1);
    typedef enum logic [2:0] {
        IDLE, LO, HI, WRITE, DONE
`ifdef LOADER_CHECKSUM_EN
        , CK_LO, CK_HI
`endif
    } loader_state_t;
endpackage

// File: rtl/loader_cksum.sv
// loader_cksum: mod-256 sum of the written program bytes.
// Built only when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_cksum
    import prog_loader_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  clear,
    input  logic  add_en,
    input  data_t add_data,
    output data_t sum
);
    data_t sum_q;
    always_ff @(posedge clock) begin
        if (reset || clear) sum_q <= '0;
        else if (add_en) sum_q <= sum_q + add_data;
    end
    assign sum = sum_q;
endmodule
`endif

// File: rtl/prog_loader.sv
// prog_loader: assembles nibble pairs into 16 program bytes while holding the cpu.
// LOADER_CHECKSUM_EN adds a trailing checksum byte and the error flag.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [3:0] in_nibble,
    output logic       in_ready,
    output logic       wr_en,
    output addr_t      wr_addr,
    output data_t      wr_data,
    output logic       cpu_hold,
    output logic       done,
    output logic       error
);
    loader_state_t state_q, state_d;
    addr_t         addr_q, addr_d;
    data_t         data_q, data_d;
    logic [3:0]    lo_q, lo_d;
    logic          xfer, launch;

    assign xfer   = in_valid && in_ready;
    assign launch = start && (state_q == IDLE || state_q == DONE);

`ifdef LOADER_CHECKSUM_EN
    logic  error_q, error_d;
    data_t sum;
    loader_cksum u_cksum (
        .clock    (clock),
        .reset    (reset),
        .clear    (launch),
        .add_en   (state_q == WRITE),
        .add_data (data_q),
        .sum      (sum)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
`ifdef LOADER_CHECKSUM_EN
            error_q <= error_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lo_d    = lo_q;
`ifdef LOADER_CHECKSUM_EN
        error_d = error_q;
`endif
        case (state_q)
            IDLE, DONE: if (launch) begin
                state_d = LO;
                addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                error_d = 1'b0;
`endif
            end
            LO: if (xfer) begin
                lo_d    = in_nibble;
                state_d = HI;
            end
            HI: if (xfer) begin
                data_d  = {in_nibble, lo_q};
                state_d = WRITE;
            end
            WRITE: begin
                // the address parks on the last word instead of wrapping
                addr_d  = (addr_q == LAST_ADDR) ? addr_q : addr_q + addr_t'(1);
`ifdef LOADER_CHECKSUM_EN
                state_d = (addr_q == LAST_ADDR) ? CK_LO : LO;
`else
                state_d = (addr_q == LAST_ADDR) ? DONE : LO;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CK_LO: if (xfer) begin
                lo_d    = in_nibble;
                state_d = CK_HI;
            end
            CK_HI: if (xfer) begin
                error_d = (sum + {in_nibble, lo_q}) != 8'd0;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = state_q == LO || state_q == HI
`ifdef LOADER_CHECKSUM_EN
                   || state_q == CK_LO || state_q == CK_HI
`endif
                   ;
        wr_en    = state_q == WRITE;
        wr_addr  = addr_q;
        wr_data  = data_q;
        cpu_hold = state_q != IDLE && state_q != DONE;
        done     = state_q == DONE;
`ifdef LOADER_CHECKSUM_EN
        error    = error_q;
`else
        error    = 1'b0;
`endif
    end
endmodule
